// File: rtl/mem_dump_addr_encode.sv
// Memory dump address encoder: walks word indices, rebuilds CPU byte addresses, streams {addr, data} pairs.
// Latency: 3 cycles per word (READ, CAPTURE, SEND) with out_ready high; SEND holds the pair until accepted.
// Optional DUMP_CHECKSUM_EN adds o_checksum, the modulo sum of all accepted data words.
module mem_dump_addr_encode #(
    parameter int                 LENGTH        = 32,
    parameter int                 IDX_W         = 10,
    parameter logic [LENGTH-1:0]  TEXT_BASE     = 32'h00400000,
    parameter logic [LENGTH-1:0]  DATA_BASE     = 32'h10010000,
    parameter logic [LENGTH-1:0]  STACK_TOP     = 32'h7FFFEFFC,
    parameter logic [LENGTH-1:0]  STACK_TOP_IDX = 'h40
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [1:0]        i_region,
    input  logic [IDX_W-1:0]  i_start_idx,
    input  logic [IDX_W-1:0]  i_count,
    input  logic              i_abort,
    output logic [IDX_W-1:0]  o_mem_idx,
    output logic              o_mem_rd,
    input  logic [LENGTH-1:0] i_mem_rdata,
    output logic [LENGTH-1:0] o_out_addr,
    output logic [LENGTH-1:0] o_out_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_busy,
    output logic              o_done
`ifdef DUMP_CHECKSUM_EN
    ,
    output logic [LENGTH-1:0] o_checksum
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CAPTURE,
        S_SEND,
        S_FINISH
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_region;
    logic [IDX_W-1:0]   r_cur_idx;
    logic [IDX_W-1:0]   r_remain;
    logic [LENGTH-1:0]  r_out_addr;
    logic [LENGTH-1:0]  r_out_data;
    logic               r_out_valid;
    logic               w_start_ok;
    logic               w_abort_ok;
    logic               w_accept;

    // Stack grows downward from STACK_TOP; indices above STACK_TOP_IDX wrap modulo 2^LENGTH.
    function automatic logic [LENGTH-1:0] encode(input logic [1:0] region,
                                                 input logic [IDX_W-1:0] idx);
        logic [LENGTH-1:0] w_x;
        w_x = LENGTH'(idx);
        case (region)
            2'd0:    encode = TEXT_BASE + (w_x << 2);
            2'd2:    encode = STACK_TOP - ((STACK_TOP_IDX - w_x) << 2);
            default: encode = DATA_BASE + (w_x << 2);
        endcase
    endfunction

    assign w_start_ok = (r_state == S_IDLE) && i_start;
    assign w_abort_ok = i_abort && (r_state != S_IDLE);
    // Abort beats a same-cycle handshake: that word is not counted as sent.
    assign w_accept   = (r_state == S_SEND) && r_out_valid && i_out_ready && !i_abort;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_next = (i_count == '0) ? S_FINISH : S_READ;
            S_READ:    w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_SEND;
            S_SEND:    if (w_accept) w_next = (r_remain == IDX_W'(1)) ? S_FINISH : S_READ;
            S_FINISH:  w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
        if (w_abort_ok && r_state != S_FINISH) w_next = S_FINISH;
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_region    <= 2'd0;
            r_cur_idx   <= '0;
            r_remain    <= '0;
            r_out_addr  <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start_ok) begin
                r_region  <= i_region;
                r_cur_idx <= i_start_idx;
                r_remain  <= i_count;
            end
            if (r_state == S_CAPTURE && !i_abort) begin
                r_out_data  <= i_mem_rdata;
                r_out_addr  <= encode(r_region, r_cur_idx);
                r_out_valid <= 1'b1;
            end
            if (w_accept) begin
                r_out_valid <= 1'b0;
                r_cur_idx   <= r_cur_idx + IDX_W'(1);
                r_remain    <= r_remain - IDX_W'(1);
            end
            if (w_abort_ok) r_out_valid <= 1'b0;
        end
    end

`ifdef DUMP_CHECKSUM_EN
    logic [LENGTH-1:0] r_checksum;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + r_out_data;
        end
    end

    assign o_checksum = r_checksum;
`endif

    assign o_mem_idx   = r_cur_idx;
    assign o_mem_rd    = (r_state == S_READ);
    assign o_out_addr  = r_out_addr;
    assign o_out_data  = r_out_data;
    assign o_out_valid = r_out_valid;
    assign o_busy      = (r_state != S_IDLE);
    assign o_done      = (r_state == S_FINISH);

endmodule

// File: tb/tb_mem_dump_addr_encode.sv
// Directed bench for mem_dump_addr_encode with a memory model and an {addr, data} scoreboard.
module tb_mem_dump_addr_encode;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  region = 2'd0;
    logic [9:0]  start_idx = '0;
    logic [9:0]  count = '0;
    logic        abort = 1'b0;
    logic [9:0]  mem_idx;
    logic        mem_rd;
    logic [31:0] mem_rdata = '0;
    logic [31:0] out_addr;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        done;
`ifdef DUMP_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    logic [31:0] mem [0:1023];
    logic [63:0] sb [$];
    int          hs_cyc [$];
    int          cyc = 0;
    int          hs_count = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          done_cyc = 0;

    mem_dump_addr_encode dut (
        .i_clock     (clk),
        .i_reset     (rst_n),
        .i_start     (start),
        .i_region    (region),
        .i_start_idx (start_idx),
        .i_count     (count),
        .i_abort     (abort),
        .o_mem_idx   (mem_idx),
        .o_mem_rd    (mem_rd),
        .i_mem_rdata (mem_rdata),
        .o_out_addr  (out_addr),
        .o_out_data  (out_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_busy      (busy),
        .o_done      (done)
`ifdef DUMP_CHECKSUM_EN
        ,
        .o_checksum  (checksum)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd) mem_rdata <= mem[mem_idx];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model_addr(input logic [1:0] r, input logic [9:0] idx);
        logic [31:0] x;
        x = {22'd0, idx};
        if (r == 2'd0)      return 32'h00400000 + x * 4;
        else if (r == 2'd2) return 32'h7FFFEFFC - (32'h40 - x) * 4;
        else                return 32'h10010000 + x * 4;
    endfunction

    // Scoreboard consumer: every handshake pops and compares one expected pair.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !abort) begin
            hs_count++;
            hs_cyc.push_back(cyc);
            chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) chk("pair", {out_addr, out_data}, sb.pop_front());
        end
    end

    task automatic launch(input logic [1:0] r, input logic [9:0] sidx, input logic [9:0] n);
        logic [9:0] idx;
        for (int i = 0; i < int'(n); i++) begin
            idx = sidx + 10'(i);
            sb.push_back({model_addr(r, idx), mem[idx]});
        end
        hs_cyc.delete();
        hs_count = 0;
        @(posedge clk); #1;
        region = r; start_idx = sidx; count = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) begin seen = 1'b1; done_cyc = cyc; end
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hC000_0000 + 32'(i);
        mem[0] = 32'hA0; mem[1] = 32'hA1; mem[2] = 32'hA2;
        mem[10'h3FF] = 32'hFFFFFFFF;
        mem[0]       = 32'hA0;

        // Reset state
        #12;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_done",  64'(done), 64'd0);
        chk("rst_mem_rd", 64'(mem_rd), 64'd0);
        chk("rst_addr_data", {out_addr, out_data}, 64'd0);
        chk("rst_mem_idx", 64'(mem_idx), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Text region, 3 words, full throughput
        launch(2'd0, 10'd0, 10'd3);
        wait_done("text_done", 40);
        chk("text_hs_count", 64'(hs_count), 64'd3);
        if (hs_cyc.size() == 3) begin
            chk("text_gap", 64'(hs_cyc[1] - hs_cyc[0]), 64'd3);
            chk("text_span", 64'(hs_cyc[2] - hs_cyc[0]), 64'd6);
            chk("text_done_lat", 64'(done_cyc - hs_cyc[2]), 64'd1);
        end
        @(negedge clk);
        chk("text_done_pulse", 64'(done), 64'd0);
        chk("text_idle", 64'(busy), 64'd0);

        // Stack region straddling STACK_TOP_IDX
        launch(2'd2, 10'h3E, 10'd3);
        wait_done("stack_done", 40);
        chk("stack_hs_count", 64'(hs_count), 64'd3);

        // Data region, index wrap, stalled consumer
        out_ready = 1'b0;
        launch(2'd1, 10'h3FF, 10'd2);
        wait_valid("stall_valid", 20);
        for (int i = 0; i < 5; i++) begin
            chk("stall_hold", {31'd0, out_valid, out_addr, out_data},
                {31'd0, 1'b1, 32'h10010FFC, 32'hFFFFFFFF});
            @(posedge clk); #1;
            @(negedge clk);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_done("wrap_done", 40);
        chk("wrap_hs_count", 64'(hs_count), 64'd2);
`ifdef DUMP_CHECKSUM_EN
        // idx 0x3FF carries 0xFFFFFFFF; idx 0 carries 0xA0
        chk("checksum_wrap", 64'(checksum), 64'h9F);
`endif

        // count=0: straight to FINISH, no memory read
        launch(2'd0, 10'd5, 10'd0);
        @(negedge clk);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_no_rd", 64'(mem_rd), 64'd0);
        @(negedge clk);
        chk("zero_done_once", 64'(done), 64'd0);
        chk("zero_hs", 64'(hs_count), 64'd0);

        // Abort during second SEND, ready high the same cycle
        launch(2'd0, 10'h10, 10'd4);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid && hs_count == 1) break;
        end
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_done", 64'(done), 64'd1);
        chk("abort_hs", 64'(hs_count), 64'd1);
        chk("abort_left", 64'(sb.size()), 64'd3);
        sb.delete();
        @(negedge clk);
        chk("abort_idle", 64'(busy), 64'd0);

`ifdef DUMP_CHECKSUM_EN
        mem[10'h20] = 32'hFFFFFFFF; mem[10'h21] = 32'h00000002;
        launch(2'd1, 10'h20, 10'd2);
        wait_done("cks_done", 40);
        chk("checksum", 64'(checksum), 64'h1);
`endif

        // Asynchronous reset while a pair is held in SEND
        out_ready = 1'b0;
        launch(2'd1, 10'd7, 10'd2);
        wait_valid("rst_mid_valid", 20);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_outs", {out_addr, out_data}, 64'd0);
        chk("rst_mid_flags", {60'd0, out_valid, busy, done, mem_rd}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_mid_nodone", 64'(done), 64'd0);
        end
        sb.delete();
        @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_idle", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_dump_addr_encode.md
Name: mem_dump_addr_encode

Overview:
- Reverse of the CPU-side address decode: walks a range of memory word indices and rebuilds the CPU byte address for each word.
- Streams {byte address, data word} pairs over a valid/ready handshake toward the UART transmit path, for memory dumps and debug.
- Sits between the data/program memory read port and the UART formatter.
- Covers three regions: text, data and stack.

Parameters:
LENGTH, 32, address/data width
IDX_W, 10, word-index width on the memory read port
TEXT_BASE, 32'h00400000, byte address of text word index 0
DATA_BASE, 32'h10010000, byte address of data word index 0
STACK_TOP, 32'h7FFFEFFC, byte address of stack word STACK_TOP_IDX
STACK_TOP_IDX, 'h40, word index corresponding to STACK_TOP

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; begins a dump (ignored unless IDLE)
region  in  2  0=text, 1=data, 2=stack, 3=reserved (treated as data)
start_idx  in  IDX_W  first word index
count  in  IDX_W  number of words to dump
abort  in  1  terminates an active dump
mem_idx  out  IDX_W  word index to memory read port
mem_rd  out  1  read strobe
mem_rdata  in  LENGTH  read data, valid one cycle after mem_rd
out_addr  out  LENGTH  reconstructed byte address
out_data  out  LENGTH  word data
out_valid  out  1  pair valid
out_ready  in  1  consumer accepts pair
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse at end of dump

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; mem_idx=0, mem_rd=0, out_addr=0, out_data=0, out_valid=0, busy=0, done=0; internal counters cleared.
- States: IDLE, READ, CAPTURE, SEND, FINISH.
- IDLE, start=1:
  - latch region, cur_idx=start_idx, remain=count.
  - count=0 -> FINISH; else -> READ.
- READ: mem_idx=cur_idx, mem_rd=1 for exactly one cycle -> CAPTURE.
- CAPTURE (one cycle after mem_rd):
  - out_data<=mem_rdata; out_addr<=encode(region, cur_idx); out_valid<=1 -> SEND.
- SEND:
  - out_addr and out_data held stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready: out_valid<=0, cur_idx<=cur_idx+1, remain<=remain-1.
  - remain==1 at acceptance -> FINISH; else -> READ.
  - Throughput: one word per 3 cycles with out_ready tied high.
- FINISH: done=1 for one cycle -> IDLE.
- Encoding (LENGTH-bit, modulo 2^LENGTH):
  - text: TEXT_BASE + (idx<<2)
  - data/reserved: DATA_BASE + (idx<<2)
  - stack: STACK_TOP - ((STACK_TOP_IDX - idx)<<2); idx is zero-extended to LENGTH before subtraction; idx>STACK_TOP_IDX wraps naturally.
- Index wrap: cur_idx at 2^IDX_W-1 increments to 0; the dump continues and no error is flagged.
- abort=1 in any non-IDLE state: out_valid<=0, mem_rd<=0, next state FINISH (done pulses). abort has priority over a same-cycle handshake; that word counts as not sent.
- start while busy: ignored.
- Simultaneous start and abort in IDLE: start wins, abort ignored.
- Reset mid-dump: immediate return to reset values; no done pulse.

Optional Feature:
DUMP_CHECKSUM_EN
- Defined:
  - adds output checksum [LENGTH-1:0].
  - Cleared on accepted start; adds out_data (mod 2^LENGTH) on each accepted handshake.
  - Holds its value from FINISH until the next start; reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset asserted mid-SEND with out_valid=1 -> all outputs 0 immediately (asynchronous), state IDLE, no done pulse.
- region=0, start_idx=0, count=3, out_ready=1, memory returns 0xA0,0xA1,0xA2 -> out_addr 0x00400000, 0x00400004, 0x00400008 with matching data; done one cycle after third handshake.
- region=2, start_idx=0x3E, count=3 -> out_addr 0x7FFFEFF4, 0x7FFFEFF8, 0x7FFFEFFC.
- region=1, start_idx=0x3FF, count=2, out_ready low 5 cycles on first word -> first pair held stable at 0x10010FFC; second word idx 0 -> 0x10010000.
- count=0 start -> no mem_rd, done pulses at cycle 2; abort during second SEND of count=4 -> out_valid drops, done pulses, only 1 handshake recorded.
- With DUMP_CHECKSUM_EN, data 0xFFFFFFFF, 0x00000002 -> checksum=0x00000001 after done.
